// File: rtl/wb_stage_queued.sv
// rtl/wb_stage_queued.sv - Writeback stage with in-order retire queue, load extraction and bypass lookup.
// Optional retire trace on debug_wb_* enabled by defining WB_DEBUG_TRACE_EN.
module wb_stage_queued #(
   parameter int DEPTH  = 4,
   parameter int REG_AW = 5,
   parameter int PC_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  logic              in_wen,
   input  logic [REG_AW-1:0] in_waddr,
   input  logic [2:0]        in_mem_op,
   input  logic [31:0]       in_alu_res,
   input  logic [31:0]       in_ld_data,
   input  logic              rf_busy,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [31:0]       rf_wdata,
   input  logic [REG_AW-1:0] byp_raddr,
   output logic              byp_hit,
   output logic [31:0]       byp_data,
   output logic [PC_W-1:0]   debug_wb_pc,
   output logic [3:0]        debug_wb_rf_wen,
   output logic [REG_AW-1:0] debug_wb_rf_wnum,
   output logic [31:0]       debug_wb_rf_wdata
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DEPTH-1:0]  q_valid;
   logic              q_wen   [DEPTH];
   logic [REG_AW-1:0] q_waddr [DEPTH];
   logic [2:0]        q_op    [DEPTH];
   logic [31:0]       q_alu   [DEPTH];
   logic [31:0]       q_ld    [DEPTH];

   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          push, pop, not_empty;

   // Shared by the head write path and the bypass path so both see identical data.
   function automatic logic [31:0] extract(input logic [2:0] op, input logic [31:0] alu,
                                           input logic [31:0] ld);
      logic [7:0]  b;
      logic [15:0] h;
      case (alu[1:0])
         2'd0:    b = ld[7:0];
         2'd1:    b = ld[15:8];
         2'd2:    b = ld[23:16];
         default: b = ld[31:24];
      endcase
      h = alu[1] ? ld[31:16] : ld[15:0];
      case (op)
         3'b000:  extract = alu;
         3'b001:  extract = {{24{b[7]}}, b};
         3'b010:  extract = {{16{h[15]}}, h};
         3'b011:  extract = ld;
         3'b101:  extract = {24'd0, b};
         3'b110:  extract = {16'd0, h};
         default: extract = 32'd0;
      endcase
   endfunction

   assign not_empty = (count != '0);
   assign in_ready  = (count != CW'(DEPTH));
   assign push      = in_valid & in_ready;
   assign pop       = not_empty & !rf_busy;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         q_valid <= '0;
      end else begin
         if (push) begin
            q_valid[wr_ptr] <= 1'b1;
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (pop) begin
            q_valid[rd_ptr] <= 1'b0;
            rd_ptr          <= rd_ptr + 1'b1;
         end
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
      end
   end

   // Payload needs no reset; the valid bits and count gate every use of it.
   always_ff @(posedge clk) begin
      if (push) begin
         q_wen[wr_ptr]   <= in_wen;
         q_waddr[wr_ptr] <= in_waddr;
         q_op[wr_ptr]    <= in_mem_op;
         q_alu[wr_ptr]   <= in_alu_res;
         q_ld[wr_ptr]    <= in_ld_data;
      end
   end

   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = '0;
      rf_wdata = '0;
      if (not_empty) begin
         rf_waddr = q_waddr[rd_ptr];
         rf_wdata = extract(q_op[rd_ptr], q_alu[rd_ptr], q_ld[rd_ptr]);
         rf_we    = !rf_busy & q_wen[rd_ptr] & (q_waddr[rd_ptr] != '0);
      end
   end

   // Walk oldest to youngest so the last match found is the youngest writer.
   always_comb begin
      logic [PW-1:0] idx;
      byp_hit  = 1'b0;
      byp_data = '0;
      idx      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + PW'(i);
         if (q_valid[idx] && q_wen[idx] && (q_waddr[idx] == byp_raddr) && (byp_raddr != '0)) begin
            byp_hit  = 1'b1;
            byp_data = extract(q_op[idx], q_alu[idx], q_ld[idx]);
         end
      end
   end

`ifdef WB_DEBUG_TRACE_EN
   logic [PC_W-1:0] q_pc [DEPTH];

   always_ff @(posedge clk) begin
      if (push)
         q_pc[wr_ptr] <= in_pc;
   end

   assign debug_wb_pc       = pop ? q_pc[rd_ptr] : '0;
   assign debug_wb_rf_wen   = {4{rf_we}};
   assign debug_wb_rf_wnum  = rf_waddr;
   assign debug_wb_rf_wdata = rf_wdata;
`else
   logic unused_pc;
   assign unused_pc         = ^in_pc;
   assign debug_wb_pc       = '0;
   assign debug_wb_rf_wen   = '0;
   assign debug_wb_rf_wnum  = '0;
   assign debug_wb_rf_wdata = '0;
`endif

endmodule

// File: tb/tb_wb_stage_queued.sv
// tb/tb_wb_stage_queued.sv - Directed self-checking bench for wb_stage_queued.
module tb_wb_stage_queued;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_pc = '0;
   logic        in_wen = 1'b0;
   logic [4:0]  in_waddr = '0;
   logic [2:0]  in_mem_op = '0;
   logic [31:0] in_alu_res = '0;
   logic [31:0] in_ld_data = '0;
   logic        rf_busy = 1'b0;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [4:0]  byp_raddr = '0;
   logic        byp_hit;
   logic [31:0] byp_data;
   logic [31:0] debug_wb_pc;
   logic [3:0]  debug_wb_rf_wen;
   logic [4:0]  debug_wb_rf_wnum;
   logic [31:0] debug_wb_rf_wdata;

   int n_pass = 0;
   int n_total = 0;

   wb_stage_queued #(.DEPTH(4), .REG_AW(5), .PC_W(32)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_wen(in_wen),
      .in_waddr(in_waddr), .in_mem_op(in_mem_op), .in_alu_res(in_alu_res),
      .in_ld_data(in_ld_data), .rf_busy(rf_busy),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .byp_raddr(byp_raddr), .byp_hit(byp_hit), .byp_data(byp_data),
      .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
      .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [4:0]  waddr;
      logic [2:0]  op;
      logic [31:0] alu;
      logic [31:0] ld;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic push(input logic w, input logic [4:0] a, input logic [2:0] op,
                       input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc);
      @(negedge clk);
      in_valid   = 1'b1;
      in_wen     = w;
      in_waddr   = a;
      in_mem_op  = op;
      in_alu_res = alu;
      in_ld_data = ld;
      in_pc      = pc;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   function automatic logic [31:0] exp_dbg_pc(input logic [31:0] pc);
`ifdef WB_DEBUG_TRACE_EN
      return pc;
`else
      return 32'd0;
`endif
   endfunction

   function automatic logic [31:0] exp_dbg_wen(input logic we);
`ifdef WB_DEBUG_TRACE_EN
      return {28'd0, {4{we}}};
`else
      return 32'd0;
`endif
   endfunction

   initial begin
      vecs[0] = '{5'd5,  3'b000, 32'h12345678, 32'h0,        32'h12345678};
      vecs[1] = '{5'd1,  3'b001, 32'h10000002, 32'h80FF7F01, 32'hFFFFFFFF};
      vecs[2] = '{5'd2,  3'b101, 32'h10000003, 32'h80FF7F01, 32'h00000080};
      vecs[3] = '{5'd3,  3'b010, 32'h10000002, 32'h80FF7F01, 32'hFFFF80FF};
      vecs[4] = '{5'd4,  3'b110, 32'h10000000, 32'h80FF7F01, 32'h00007F01};
      vecs[5] = '{5'd6,  3'b011, 32'h10000000, 32'h80FF7F01, 32'h80FF7F01};
      vecs[6] = '{5'd7,  3'b101, 32'h10000001, 32'h80FF7F01, 32'h0000007F};
      vecs[7] = '{5'd8,  3'b010, 32'h10000001, 32'h80FF7F01, 32'h00007F01};
      vecs[8] = '{5'd9,  3'b001, 32'h10000000, 32'h80FF7F01, 32'h00000001};
      vecs[9] = '{5'd10, 3'b111, 32'h10000000, 32'h80FF7F01, 32'h00000000};

      #12;
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
      chk("reset_rf_we", {31'd0, rf_we}, 32'd0);
      chk("reset_rf_waddr", {27'd0, rf_waddr}, 32'd0);
      chk("reset_rf_wdata", rf_wdata, 32'd0);
      chk("reset_byp_hit", {31'd0, byp_hit}, 32'd0);
      chk("reset_dbg_pc", debug_wb_pc, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Table: each entry reaches the head one cycle after its push.
      for (int k = 0; k < 10; k++) begin
         push(1'b1, vecs[k].waddr, vecs[k].op, vecs[k].alu, vecs[k].ld, 32'h1c000000 + 32'(4*k));
         chk($sformatf("vec%0d_rf_we", k), {31'd0, rf_we}, 32'd1);
         chk($sformatf("vec%0d_rf_waddr", k), {27'd0, rf_waddr}, {27'd0, vecs[k].waddr});
         chk($sformatf("vec%0d_rf_wdata", k), rf_wdata, vecs[k].exp);
         chk($sformatf("vec%0d_in_ready", k), {31'd0, in_ready}, 32'd1);
         chk($sformatf("vec%0d_dbg_pc", k), debug_wb_pc, exp_dbg_pc(32'h1c000000 + 32'(4*k)));
         chk($sformatf("vec%0d_dbg_wen", k), {28'd0, debug_wb_rf_wen}, exp_dbg_wen(1'b1));
      end
      @(posedge clk); #1;
      chk("drain_rf_we", {31'd0, rf_we}, 32'd0);
      chk("drain_rf_waddr", {27'd0, rf_waddr}, 32'd0);

      // Fill under stall, attempt an overflow push, then drain in order.
      rf_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push(1'b1, 5'(i + 1), 3'b000, 32'h100 + 32'(i), 32'h0, 32'h2000 + 32'(i));
         chk($sformatf("fill%0d_in_ready", i), {31'd0, in_ready}, (i < 3) ? 32'd1 : 32'd0);
         chk($sformatf("fill%0d_rf_we", i), {31'd0, rf_we}, 32'd0);
      end
      push(1'b1, 5'd9, 3'b000, 32'h999, 32'h0, 32'h2999);
      chk("full_in_ready", {31'd0, in_ready}, 32'd0);
      rf_busy = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("drain%0d_rf_we", i), {31'd0, rf_we}, 32'd1);
         chk($sformatf("drain%0d_rf_waddr", i), {27'd0, rf_waddr}, 32'(i + 1));
         chk($sformatf("drain%0d_rf_wdata", i), rf_wdata, 32'h100 + 32'(i));
         @(posedge clk); #1;
         chk($sformatf("drain%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      end
      chk("after_drain_rf_we", {31'd0, rf_we}, 32'd0);

      // Bypass: youngest matching writer wins.
      rf_busy = 1'b1;
      push(1'b1, 5'd3, 3'b000, 32'h11, 32'h0, 32'h3000);
      push(1'b1, 5'd3, 3'b000, 32'h22, 32'h0, 32'h3004);
      push(1'b1, 5'd7, 3'b000, 32'h33, 32'h0, 32'h3008);
      byp_raddr = 5'd3; #1;
      chk("byp3_hit", {31'd0, byp_hit}, 32'd1);
      chk("byp3_data", byp_data, 32'h22);
      byp_raddr = 5'd7; #1;
      chk("byp7_data", byp_data, 32'h33);
      byp_raddr = 5'd0; #1;
      chk("byp0_hit", {31'd0, byp_hit}, 32'd0);
      byp_raddr = 5'd9; #1;
      chk("byp9_hit", {31'd0, byp_hit}, 32'd0);
      chk("byp9_data", byp_data, 32'd0);
      @(negedge clk);
      in_valid = 1'b1; in_wen = 1'b1; in_waddr = 5'd9; in_mem_op = 3'b000; in_alu_res = 32'h44;
      #1;
      chk("byp_inflight_hit", {31'd0, byp_hit}, 32'd0);
      in_valid = 1'b0;

      // Async reset with three entries queued.
      rf_busy = 1'b0; #1;
      chk("pre_reset_rf_we", {31'd0, rf_we}, 32'd1);
      chk("pre_reset_rf_waddr", {27'd0, rf_waddr}, 32'd3);
      byp_raddr = 5'd7;
      reset = 1'b1; #1;
      chk("async_rst_rf_we", {31'd0, rf_we}, 32'd0);
      chk("async_rst_rf_wdata", rf_wdata, 32'd0);
      chk("async_rst_byp_hit", {31'd0, byp_hit}, 32'd0);
      chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk($sformatf("post_rst%0d_rf_we", i), {31'd0, rf_we}, 32'd0);
      end

      // Writes to r0 and wen=0 entries retire silently.
      byp_raddr = 5'd0;
      push(1'b1, 5'd0, 3'b000, 32'hDEAD, 32'h0, 32'h4000);
      chk("r0_rf_we", {31'd0, rf_we}, 32'd0);
      chk("r0_byp_hit", {31'd0, byp_hit}, 32'd0);
      chk("r0_dbg_pc", debug_wb_pc, exp_dbg_pc(32'h4000));
      byp_raddr = 5'd6;
      push(1'b0, 5'd6, 3'b000, 32'h66, 32'h0, 32'h4004);
      chk("nowen_rf_we", {31'd0, rf_we}, 32'd0);
      chk("nowen_byp_hit", {31'd0, byp_hit}, 32'd0);
      chk("nowen_dbg_pc", debug_wb_pc, exp_dbg_pc(32'h4004));
      @(posedge clk); #1;
      chk("idle_dbg_pc", debug_wb_pc, 32'd0);
      chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
